// File: rtl/prime_cert_loader_pkg.sv
// Shared types and constants for the certificate loader: FSM encodings,
// error codes, field selectors and record-layout helpers.
package prime_cert_pkg;

   localparam logic [1:0] S_LOAD    = 2'd0;
   localparam logic [1:0] S_PRESENT = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;

   localparam logic [1:0] ERR_SHORT = 2'b01;
   localparam logic [1:0] ERR_LONG  = 2'b10;
   localparam logic [1:0] ERR_RANGE = 2'b11;

   localparam int OFS_PRIMES = 3;

   typedef enum logic [2:0] {
      FLD_TARGET,
      FLD_FACT1,
      FLD_FACT2,
      FLD_PRIMES,
      FLD_GENS,
      FLD_POWS
   } cert_field_e;

   function automatic int cert_total(input int n);
      return 3 + 2*n + n*n;
   endfunction

   function automatic int ofs_gens(input int n);
      return n + 3;
   endfunction

   function automatic int ofs_pows(input int n);
      return 2*n + 3;
   endfunction

endpackage

// File: rtl/prime_cert_loader_if.sv
// Word-stream input and assembled-record output of the certificate loader.
interface prime_cert_loader_if #(
   parameter int BIT_WIDTH = 4,
   parameter int N         = 4
);
   logic                       in_valid;
   logic                       in_ready;
   logic [BIT_WIDTH-1:0]       in_data;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [BIT_WIDTH-1:0]       target;
   logic [BIT_WIDTH-1:0]       fact1;
   logic [BIT_WIDTH-1:0]       fact2;
   logic [BIT_WIDTH*N-1:0]     all_primes;
   logic [BIT_WIDTH*N-1:0]     generators;
   logic [BIT_WIDTH*N*N-1:0]   pows;
   logic                       err;
   logic [1:0]                 err_code;
   logic [15:0]                rec_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, target, fact1, fact2, all_primes,
             generators, pows, err, err_code, rec_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, target, fact1, fact2, all_primes,
             generators, pows, err, err_code, rec_count
   );
endinterface

// File: rtl/prime_cert_loader_field_decode.sv
// Maps a record word index to the destination field and the slot within it.
module cert_field_decode
   import prime_cert_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = 5,
   parameter int SW = 4
) (
   input  logic [IW-1:0] idx,
   output cert_field_e   fld,
   output logic [SW-1:0] slot
);
   localparam int OG = ofs_gens(N);
   localparam int OP = ofs_pows(N);

   always_comb begin
      int pos;
      pos  = int'(idx);
      fld  = FLD_TARGET;
      slot = '0;
      if (pos == 1) begin
         fld = FLD_FACT1;
      end else if (pos == 2) begin
         fld = FLD_FACT2;
      end else if (pos >= OP) begin
         fld  = FLD_POWS;
         slot = SW'(pos - OP);
      end else if (pos >= OG) begin
         fld  = FLD_GENS;
         slot = SW'(pos - OG);
      end else if (pos >= OFS_PRIMES) begin
         fld  = FLD_PRIMES;
         slot = SW'(pos - OFS_PRIMES);
      end
   end
endmodule

// File: rtl/prime_cert_loader.sv
// Certificate loader: assembles a word stream into a full certificate record.
// Define CERT_RANGE_CHECK_EN to reject records whose primes contain 0 or 1.
//
// state     | meaning
// S_LOAD    | accepting words into fields selected by idx
// S_PRESENT | record complete, out_valid high until consumer takes it
// S_DRAIN   | record overran its length, discard words up to in_last
module prime_cert_loader
   import prime_cert_pkg::*;
#(
   parameter int BIT_WIDTH = 4,
   parameter int N         = 4
) (
   input logic               clk,
   input logic               rst_n,
   prime_cert_loader_if.slave bus
);
   localparam int TOTAL = cert_total(N);
   localparam int IW    = $clog2(TOTAL);
   localparam int SW    = $clog2(N*N);

   logic [1:0]                state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [BIT_WIDTH-1:0]      target_q, target_d;
   logic [BIT_WIDTH-1:0]      fact1_q, fact1_d;
   logic [BIT_WIDTH-1:0]      fact2_q, fact2_d;
   logic [BIT_WIDTH*N-1:0]    primes_q, primes_d;
   logic [BIT_WIDTH*N-1:0]    gens_q, gens_d;
   logic [BIT_WIDTH*N*N-1:0]  pows_q, pows_d;
   logic                      err_q, err_d;
   logic [1:0]                err_code_q, err_code_d;
   logic [15:0]               rec_count_q, rec_count_d;

   cert_field_e   fld;
   logic [SW-1:0] slot;
   logic          accept;
   logic          idx_last;
   logic          range_bad;

   cert_field_decode #(.N(N), .IW(IW), .SW(SW)) u_decode (
      .idx  (idx_q),
      .fld  (fld),
      .slot (slot)
   );

   assign accept   = bus.in_valid && (state_q != S_PRESENT);
   assign idx_last = (idx_q == IW'(TOTAL-1));

`ifdef CERT_RANGE_CHECK_EN
   logic range_flag_q, range_flag_d;
   logic word_bad;

   assign word_bad  = accept && (state_q == S_LOAD) && (fld == FLD_PRIMES)
                      && (bus.in_data <= BIT_WIDTH'(1));
   assign range_bad = range_flag_q || word_bad;

   // Flag lives for exactly one record, whatever way that record ends.
   always_comb begin
      range_flag_d = range_flag_q || word_bad;
      if (accept && bus.in_last) range_flag_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) range_flag_q <= 1'b0;
      else        range_flag_q <= range_flag_d;
   end
`else
   assign range_bad = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      target_d    = target_q;
      fact1_d     = fact1_q;
      fact2_d     = fact2_q;
      primes_d    = primes_q;
      gens_d      = gens_q;
      pows_d      = pows_q;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      rec_count_d = rec_count_q;
      case (state_q)
         S_LOAD: begin
            if (accept) begin
               case (fld)
                  FLD_TARGET: target_d = bus.in_data;
                  FLD_FACT1:  fact1_d  = bus.in_data;
                  FLD_FACT2:  fact2_d  = bus.in_data;
                  FLD_PRIMES: primes_d[slot*BIT_WIDTH +: BIT_WIDTH] = bus.in_data;
                  FLD_GENS:   gens_d[slot*BIT_WIDTH +: BIT_WIDTH]   = bus.in_data;
                  default:    pows_d[slot*BIT_WIDTH +: BIT_WIDTH]   = bus.in_data;
               endcase
               if (bus.in_last) begin
                  idx_d = '0;
                  if (!idx_last) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_SHORT;
                  end else if (range_bad) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_RANGE;
                  end else begin
                     state_d = S_PRESENT;
                  end
               end else if (idx_last) begin
                  state_d = S_DRAIN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (accept && bus.in_last) begin
               err_d      = 1'b1;
               err_code_d = ERR_LONG;
               idx_d      = '0;
               state_d    = S_LOAD;
            end
         end
         S_PRESENT: begin
            if (bus.out_ready) begin
               rec_count_d = rec_count_q + 16'd1;
               idx_d       = '0;
               state_d     = S_LOAD;
            end
         end
         default: begin
            state_d = S_LOAD;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_LOAD;
         idx_q       <= '0;
         target_q    <= '0;
         fact1_q     <= '0;
         fact2_q     <= '0;
         primes_q    <= '0;
         gens_q      <= '0;
         pows_q      <= '0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
         rec_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         target_q    <= target_d;
         fact1_q     <= fact1_d;
         fact2_q     <= fact2_d;
         primes_q    <= primes_d;
         gens_q      <= gens_d;
         pows_q      <= pows_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
         rec_count_q <= rec_count_d;
      end
   end

   assign bus.in_ready   = (state_q != S_PRESENT);
   assign bus.out_valid  = (state_q == S_PRESENT);
   assign bus.target     = target_q;
   assign bus.fact1      = fact1_q;
   assign bus.fact2      = fact2_q;
   assign bus.all_primes = primes_q;
   assign bus.generators = gens_q;
   assign bus.pows       = pows_q;
   assign bus.err        = err_q;
   assign bus.err_code   = err_code_q;
   assign bus.rec_count  = rec_count_q;
endmodule

// File: tb/tb_prime_cert_loader.sv
// Self-checking bench for prime_cert_loader: directed scenarios plus random
// records judged by a record-level model (length / value rules only).
module tb_prime_cert_loader;
   localparam int BW    = 4;
   localparam int N     = 4;
   localparam int TOTAL = 3 + 2*N + N*N;

   logic clk;
   logic rst_n;

   prime_cert_loader_if #(.BIT_WIDTH(BW), .N(N)) bus ();

   prime_cert_loader #(.BIT_WIDTH(BW), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_cmp;
   int         n_mis;
   int         exp_count;
   logic [1:0] last_code;
   logic [BW-1:0] rec_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic build_rec(input int len, input bit good_primes);
      rec_q.delete();
      for (int i = 0; i < len; i++) rec_q.push_back(BW'($urandom_range(0, 15)));
      if (good_primes && len >= 3 + N)
         for (int k = 0; k < N; k++) rec_q[3+k] = BW'($urandom_range(2, 15));
   endtask

   // Sends the first n_send words of rec_q with random idle gaps.
   task automatic send_q(input int n_send, input bit last_on_final);
      for (int i = 0; i < n_send; i++) begin
         int gap;
         int t;
         gap = $urandom_range(0, 2);
         bus.in_valid = 1'b0;
         bus.in_last  = 1'b0;
         repeat (gap) tick();
         bus.in_valid = 1'b1;
         bus.in_data  = rec_q[i];
         bus.in_last  = last_on_final && (i == n_send - 1);
         t = 0;
         while (!bus.in_ready && t < 50) begin
            tick();
            t++;
         end
         if (t >= 50) check("in_ready_wait", 64'(bus.in_ready), 64'd1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   // Called one clock after the final word was accepted.
   task automatic check_record(input int hold);
      int len;
      logic [1:0] code;
      logic [BW*N-1:0]   ep;
      logic [BW*N-1:0]   eg;
      logic [BW*N*N-1:0] ew;
      len  = rec_q.size();
      code = 2'b00;
      if (len < TOTAL) code = 2'b01;
      else if (len > TOTAL) code = 2'b10;
`ifdef CERT_RANGE_CHECK_EN
      else for (int k = 0; k < N; k++) if (rec_q[3+k] <= 1) code = 2'b11;
`endif
      if (code != 2'b00) begin
         last_code = code;
         check("err_pulse", 64'(bus.err), 64'd1);
         check("err_code", 64'(bus.err_code), 64'(code));
         check("no_out_valid", 64'(bus.out_valid), 64'd0);
         tick();
         check("err_clear", 64'(bus.err), 64'd0);
         check("err_code_held", 64'(bus.err_code), 64'(code));
         check("no_out_valid2", 64'(bus.out_valid), 64'd0);
         check("in_ready_after_err", 64'(bus.in_ready), 64'd1);
      end else begin
         for (int k = 0; k < N; k++) begin
            ep[k*BW +: BW] = rec_q[3+k];
            eg[k*BW +: BW] = rec_q[3+N+k];
         end
         for (int m = 0; m < N*N; m++) ew[m*BW +: BW] = rec_q[3+2*N+m];
         check("out_valid", 64'(bus.out_valid), 64'd1);
         check("err_quiet", 64'(bus.err), 64'd0);
         check("err_code_kept", 64'(bus.err_code), 64'(last_code));
         check("in_ready_present", 64'(bus.in_ready), 64'd0);
         check("target", 64'(bus.target), 64'(rec_q[0]));
         check("fact1", 64'(bus.fact1), 64'(rec_q[1]));
         check("fact2", 64'(bus.fact2), 64'(rec_q[2]));
         check("all_primes", 64'(bus.all_primes), 64'(ep));
         check("generators", 64'(bus.generators), 64'(eg));
         check("pows", 64'(bus.pows), 64'(ew));
         for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("hold_primes", 64'(bus.all_primes), 64'(ep));
            check("hold_pows", 64'(bus.pows), 64'(ew));
            check("hold_target", 64'(bus.target), 64'(rec_q[0]));
            check("hold_count", 64'(bus.rec_count), 64'(exp_count));
         end
         bus.out_ready = 1'b1;
         tick();
         bus.out_ready = 1'b0;
         exp_count++;
         check("consumed_valid", 64'(bus.out_valid), 64'd0);
         check("rec_count", 64'(bus.rec_count), 64'(exp_count));
         check("in_ready_back", 64'(bus.in_ready), 64'd1);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      exp_count = 0;
      last_code = 2'b00;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_err", 64'(bus.err), 64'd0);
      check("rst_err_code", 64'(bus.err_code), 64'd0);
      check("rst_count", 64'(bus.rec_count), 64'd0);
      check("rst_target", 64'(bus.target), 64'd0);
      check("rst_primes", 64'(bus.all_primes), 64'd0);
      check("rst_pows", 64'(bus.pows), 64'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // Directed record with known field values
      rec_q.delete();
      rec_q.push_back(4'd7); rec_q.push_back(4'd7); rec_q.push_back(4'd1);
      rec_q.push_back(4'd2); rec_q.push_back(4'd3); rec_q.push_back(4'd5); rec_q.push_back(4'd7);
      rec_q.push_back(4'd0); rec_q.push_back(4'd2); rec_q.push_back(4'd2); rec_q.push_back(4'd3);
      for (int m = 0; m < N*N; m++) rec_q.push_back(BW'(m * 3 + 1));
      send_q(TOTAL, 1'b1);
      check("t1_primes_const", 64'(bus.all_primes), 64'h7532);
      check("t1_gens_const", 64'(bus.generators), 64'h3220);
      check("t1_target_const", 64'(bus.target), 64'h7);
      check_record(0);

      // Same record, consumer stalls five cycles
      send_q(TOTAL, 1'b1);
      check_record(5);

      // Short record, then a good one
      build_rec(11, 1'b1);
      send_q(11, 1'b1);
      check_record(0);
      build_rec(TOTAL, 1'b1);
      send_q(TOTAL, 1'b1);
      check_record(2);

      // Long record, then a good one
      build_rec(30, 1'b1);
      send_q(30, 1'b1);
      check_record(0);
      build_rec(TOTAL, 1'b1);
      send_q(TOTAL, 1'b1);
      check_record(1);

      // Prime word equal to 1
      build_rec(TOTAL, 1'b1);
      rec_q[4] = 4'd1;
      send_q(TOTAL, 1'b1);
      check_record(0);

      // Reset in the middle of a record
      build_rec(TOTAL, 1'b1);
      send_q(11, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = rec_q[11];
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check("mid_rst_count", 64'(bus.rec_count), 64'd0);
      check("mid_rst_err_code", 64'(bus.err_code), 64'd0);
      check("mid_rst_target", 64'(bus.target), 64'd0);
      check("mid_rst_pows", 64'(bus.pows), 64'd0);
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_count = 0;
      last_code = 2'b00;
      tick();
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
      build_rec(TOTAL, 1'b1);
      send_q(TOTAL, 1'b1);
      check_record(1);

      // Random mix of record lengths and contents
      repeat (24) begin
         int kind;
         int len;
         kind = $urandom_range(0, 3);
         case (kind)
            0:       len = $urandom_range(1, TOTAL - 1);
            1:       len = $urandom_range(TOTAL + 1, TOTAL + 7);
            default: len = TOTAL;
         endcase
         build_rec(len, kind == 2);
         send_q(len, 1'b1);
         check_record($urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
